// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg
//   Shared definitions for the countdown timer slice:
//   - state_t       : controller state enumeration
//   - bcd_time_t    : packed HH:MM:SS value, one BCD nibble per digit
//   - digit limits  : largest legal value of each BCD digit position
//   - time_is_legal : checks a candidate load value against the digit limits
//   - time_is_zero  : true for 00:00:00
package countdown_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOADED  = 3'd1,
        ST_RUN     = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_EXPIRED = 3'd4
    } state_t;

    // Largest value a digit may hold. The hour-ones limit drops to 3
    // when hour_ten is 2, so the largest loadable time is 23:59:59.
    localparam logic [3:0] DIGIT_MAX_NINE      = 4'd9;
    localparam logic [3:0] DIGIT_MAX_FIVE      = 4'd5;
    localparam logic [3:0] HOUR_TEN_MAX        = 4'd2;
    localparam logic [3:0] HOUR_ONE_MAX_AT_TWO = 4'd3;

    typedef struct packed {
        logic [3:0] hour_ten;
        logic [3:0] hour_one;
        logic [3:0] min_ten;
        logic [3:0] min_one;
        logic [3:0] sec_ten;
        logic [3:0] sec_one;
    } bcd_time_t;

    localparam bcd_time_t TIME_ZERO = '0;

    function automatic logic time_is_legal(input bcd_time_t t);
        logic hour_ok;
        logic min_ok;
        logic sec_ok;
        if (t.hour_ten < HOUR_TEN_MAX) begin
            hour_ok = (t.hour_one <= DIGIT_MAX_NINE);
        end else begin
            hour_ok = (t.hour_ten == HOUR_TEN_MAX) && (t.hour_one <= HOUR_ONE_MAX_AT_TWO);
        end
        min_ok = (t.min_ten <= DIGIT_MAX_FIVE) && (t.min_one <= DIGIT_MAX_NINE);
        sec_ok = (t.sec_ten <= DIGIT_MAX_FIVE) && (t.sec_one <= DIGIT_MAX_NINE);
        return hour_ok && min_ok && sec_ok;
    endfunction

    function automatic logic time_is_zero(input bcd_time_t t);
        return (t == TIME_ZERO);
    endfunction

endpackage

// File: rtl/countdown_timer_bcd_time_decrement.sv
// bcd_time_decrement
//   Purely combinational one-second decrement of an HH:MM:SS BCD value.
//   Ports:
//     *_in  (6 x 4b) : current time digits
//     *_dec (6 x 4b) : time minus one second; equals the input when the
//                      input is 00:00:00 so the value can never underflow
//     is_zero        : input value is 00:00:00
//   A digit that is zero and receives a borrow wraps to its position's
//   maximum (9 or 5) and passes the borrow on to the next digit up.
module bcd_time_decrement
    import countdown_timer_pkg::*;
(
    input  logic [3:0] hour_ten_in,
    input  logic [3:0] hour_one_in,
    input  logic [3:0] min_ten_in,
    input  logic [3:0] min_one_in,
    input  logic [3:0] sec_ten_in,
    input  logic [3:0] sec_one_in,
    output logic [3:0] hour_ten_dec,
    output logic [3:0] hour_one_dec,
    output logic [3:0] min_ten_dec,
    output logic [3:0] min_one_dec,
    output logic [3:0] sec_ten_dec,
    output logic [3:0] sec_one_dec,
    output logic       is_zero
);

    // Returns {borrow_out, new_digit}.
    function automatic logic [4:0] dec_digit(input logic [3:0] d,
                                             input logic       borrow_in,
                                             input logic [3:0] wrap_value);
        if (!borrow_in) begin
            return {1'b0, d};
        end
        if (d == 4'd0) begin
            return {1'b1, wrap_value};
        end
        return {1'b0, d - 4'd1};
    endfunction

    logic [4:0] sec_one_r;
    logic [4:0] sec_ten_r;
    logic [4:0] min_one_r;
    logic [4:0] min_ten_r;
    logic [4:0] hour_one_r;
    logic [4:0] hour_ten_r;

    always_comb begin
        is_zero = (hour_ten_in == 4'd0) && (hour_one_in == 4'd0) &&
                  (min_ten_in  == 4'd0) && (min_one_in  == 4'd0) &&
                  (sec_ten_in  == 4'd0) && (sec_one_in  == 4'd0);

        // A zero value gets no initial borrow, so every digit passes through.
        sec_one_r  = dec_digit(sec_one_in,  !is_zero,       DIGIT_MAX_NINE);
        sec_ten_r  = dec_digit(sec_ten_in,  sec_one_r[4],   DIGIT_MAX_FIVE);
        min_one_r  = dec_digit(min_one_in,  sec_ten_r[4],   DIGIT_MAX_NINE);
        min_ten_r  = dec_digit(min_ten_in,  min_one_r[4],   DIGIT_MAX_FIVE);
        hour_one_r = dec_digit(hour_one_in, min_ten_r[4],   DIGIT_MAX_NINE);
        // hour_ten can never be asked to borrow from zero on a nonzero value.
        hour_ten_r = dec_digit(hour_ten_in, hour_one_r[4],  4'd0);

        sec_one_dec  = sec_one_r[3:0];
        sec_ten_dec  = sec_ten_r[3:0];
        min_one_dec  = min_one_r[3:0];
        min_ten_dec  = min_ten_r[3:0];
        hour_one_dec = hour_one_r[3:0];
        hour_ten_dec = hour_ten_r[3:0];
    end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer
//   HH:MM:SS countdown timer with load / start / pause / clear control.
//   Parameter:
//     TICKS_PER_SEC : clock cycles per counted second (2 .. 2**26)
//   Ports:
//     clock, reset          : system clock, synchronous active-high reset
//     load                  : capture *_in digits (legal nonzero -> LOADED,
//                             all zero -> IDLE, illegal -> load_err pulse)
//     *_in (6 x 4b)         : BCD time to load
//     start / pause / clear : control pulses
//     *_out (6 x 4b)        : remaining time, BCD (the live digit registers)
//     running               : high while in RUN
//     done                  : one-cycle pulse, the cycle after EXPIRED is first seen
//     alarm                 : level, high from that same cycle until load or clear
//     load_err              : one-cycle pulse after a rejected load
//     state_dbg             : current controller state
//
//   Command pulses are sampled on every rising edge and need no handshake.
//   When several arrive together only the highest-priority one acts:
//   clear > load > pause > start. A rejected load still consumes the cycle,
//   so a pause or start arriving with it is dropped.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] hour_ten_in,
    input  logic [3:0] hour_one_in,
    input  logic [3:0] min_ten_in,
    input  logic [3:0] min_one_in,
    input  logic [3:0] sec_ten_in,
    input  logic [3:0] sec_one_in,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [3:0] hour_ten_out,
    output logic [3:0] hour_one_out,
    output logic [3:0] min_ten_out,
    output logic [3:0] min_one_out,
    output logic [3:0] sec_ten_out,
    output logic [3:0] sec_one_out,
    output logic       running,
    output logic       done,
    output logic       alarm,
    output logic       load_err,
    output state_t     state_dbg
);

    localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

    state_t             state_q;
    state_t             state_next;
    bcd_time_t          time_q;
    bcd_time_t          time_next;
    bcd_time_t          load_time;
    bcd_time_t          dec_time;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_next;
    logic               cur_zero;
    logic               load_legal;
    logic               load_zero;
    logic               presc_wrap;
    logic               load_err_next;
    logic               running_next;
    logic               alarm_next;
    logic               done_next;

    assign load_time  = {hour_ten_in, hour_one_in, min_ten_in, min_one_in, sec_ten_in, sec_one_in};
    assign load_legal = time_is_legal(load_time);
    assign load_zero  = time_is_zero(load_time);
    assign presc_wrap = (presc_q == PRESC_LAST);

    bcd_time_decrement u_dec (
        .hour_ten_in  (time_q.hour_ten),
        .hour_one_in  (time_q.hour_one),
        .min_ten_in   (time_q.min_ten),
        .min_one_in   (time_q.min_one),
        .sec_ten_in   (time_q.sec_ten),
        .sec_one_in   (time_q.sec_one),
        .hour_ten_dec (dec_time.hour_ten),
        .hour_one_dec (dec_time.hour_one),
        .min_ten_dec  (dec_time.min_ten),
        .min_one_dec  (dec_time.min_one),
        .sec_ten_dec  (dec_time.sec_ten),
        .sec_one_dec  (dec_time.sec_one),
        .is_zero      (cur_zero)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state and datapath decode. Counting in RUN is worked out first;
    // a command in the same cycle then overrides it.
    always_comb begin
        state_next    = state_q;
        time_next     = time_q;
        presc_next    = presc_q;
        load_err_next = 1'b0;

        if (state_q == ST_RUN && !cur_zero) begin
            if (presc_wrap) begin
                presc_next = '0;
                time_next  = dec_time;
                if (time_is_zero(dec_time)) begin
                    state_next = ST_EXPIRED;
                end
            end else begin
                presc_next = presc_q + PRESC_ONE;
            end
        end

        if (clear) begin
            state_next = ST_IDLE;
            time_next  = TIME_ZERO;
            presc_next = '0;
        end else if (load) begin
            if (!load_legal) begin
                load_err_next = 1'b1;
            end else if (load_zero) begin
                state_next = ST_IDLE;
                time_next  = TIME_ZERO;
                presc_next = '0;
            end else begin
                state_next = ST_LOADED;
                time_next  = load_time;
                presc_next = '0;
            end
        end else if (pause) begin
            if (state_q == ST_RUN) begin
                // Freeze exactly where we are, even on a wrap cycle.
                state_next = ST_PAUSED;
                time_next  = time_q;
                presc_next = presc_q;
            end
        end else if (start) begin
            if (state_q == ST_LOADED || state_q == ST_PAUSED) begin
                state_next = ST_RUN;
                presc_next = '0;
            end
        end
    end

    // Output decode for the registered status flags. alarm only rises once
    // EXPIRED has been held for a cycle, and done fires in that first cycle,
    // which is identified by EXPIRED with alarm still low.
    always_comb begin
        running_next = (state_next == ST_RUN);
        alarm_next   = (state_next == ST_EXPIRED) && (state_q == ST_EXPIRED);
        done_next    = (state_q == ST_EXPIRED) && !alarm;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            time_q   <= TIME_ZERO;
            presc_q  <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
            alarm    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            time_q   <= time_next;
            presc_q  <= presc_next;
            running  <= running_next;
            done     <= done_next;
            alarm    <= alarm_next;
            load_err <= load_err_next;
        end
    end

    assign hour_ten_out = time_q.hour_ten;
    assign hour_one_out = time_q.hour_one;
    assign min_ten_out  = time_q.min_ten;
    assign min_one_out  = time_q.min_one;
    assign sec_ten_out  = time_q.sec_ten;
    assign sec_one_out  = time_q.sec_one;
    assign state_dbg    = state_q;

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter TICKS_PER_SEC, default 50_000_000; number of clock cycles in one counted second; legal range 2..2^26.
REQ-002 clock  in  1  single system clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 load  in  1  one-cycle pulse; capture the six *_in digits as the new countdown value.
REQ-005 hour_ten_in, hour_one_in, min_ten_in, min_one_in, sec_ten_in, sec_one_in  in  4 each  BCD time from the shortcut/setting path.
REQ-006 start  in  1  pulse; begin or resume counting.
REQ-007 pause  in  1  pulse; freeze counting.
REQ-008 clear  in  1  pulse; abort, zero all digits, return to IDLE.
REQ-009 hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out  out  4 each  remaining time, BCD.
REQ-010 running  out  1  high while in RUN.
REQ-011 done  out  1  one-cycle pulse on expiry.
REQ-012 alarm  out  1  level; high in EXPIRED state.
REQ-013 load_err  out  1  one-cycle pulse when a load is rejected.

Function
REQ-014 States: IDLE, LOADED, RUN, PAUSED, EXPIRED.
REQ-015 Legal load value: hour_ten<=2, hour_one<=9 (<=3 when hour_ten=2), min_ten<=5, min_one<=9, sec_ten<=5, sec_one<=9.
REQ-016 load with legal nonzero value, any state -> digits captured next edge, state LOADED, alarm cleared, prescaler zeroed.
REQ-017 load with illegal value -> digits and state unchanged; load_err high for exactly the following cycle.
REQ-018 load with all-zero value -> digits zeroed, state IDLE, no done, no load_err.
REQ-019 start in LOADED or PAUSED -> RUN next edge, prescaler zeroed; start in IDLE, RUN or EXPIRED ignored.
REQ-020 pause in RUN -> PAUSED next edge, digits and prescaler held; pause elsewhere ignored.
REQ-021 clear in any state -> IDLE, digits 0, alarm 0, prescaler 0.
REQ-022 Priority in the same cycle: clear > load > pause > start.
REQ-023 In RUN the prescaler counts 0..TICKS_PER_SEC-1; on reaching TICKS_PER_SEC-1 it wraps to 0 and the time decrements by one second on that edge.
REQ-024 First decrement occurs exactly TICKS_PER_SEC cycles after the edge that entered RUN.
REQ-025 Decrement is BCD with borrow chain: sec_one 0->9 borrows from sec_ten; sec_ten 0->5 borrows from min_one; min_one 0->9 borrows from min_ten; min_ten 0->5 borrows from hour_one; hour_one 0->9 borrows from hour_ten.
REQ-026 When the decrement produces 00:00:00 the state becomes EXPIRED on that edge; done pulses high in the next cycle only; alarm high from the next cycle until load or clear.
REQ-027 Digits never underflow: no decrement occurs outside RUN or when the value is zero.
REQ-028 running, alarm and done are registered outputs; the digit outputs are the internal registers, so they change on the decrement edge.

Reset
REQ-029 On reset: state IDLE, all digits 0, prescaler 0, running 0, done 0, alarm 0, load_err 0; reset overrides all inputs.
REQ-030 Reset asserted mid-RUN aborts the countdown without a done pulse.

Structure
REQ-031 A shared package holds the state enumeration and the BCD digit limit constants (9, 5, 2, 3).
REQ-032 One sub-module, bcd_time_decrement: combinational, six digits in, six digits out, plus an is_zero flag.

Verification
REQ-033 TICKS_PER_SEC=4; load 00:00:03, start -> decrements at cycles 4, 8, 12 after RUN entry; EXPIRED at 12; done pulses once at cycle 13; alarm stays high.
REQ-034 Load 01:00:00, run 1 s -> 00:59:59; load 10:00:00, run 1 s -> 09:59:59.
REQ-035 Load 00:00:10, start, pause after 6 cycles, hold 20 cycles, then start -> value stays 00:00:09 while paused; next decrement occurs 4 cycles after resume.
REQ-036 Load with sec_ten=6 or hour 24 -> load_err pulses one cycle; digits and state unchanged.
REQ-037 Same-cycle clear+load -> IDLE with zero digits; same-cycle load+start from PAUSED -> LOADED, not RUN.
REQ-038 Reset in RUN at 00:00:01 -> all outputs 0, no done pulse.
